// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NCH prescaled up-counters with compare match, one-shot mode,
// selectable count source (clock / event edge / cascade) and level IRQ per channel.
module apb_timer_mc #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [11:0]    PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  input  logic           stoptimer_i,
  input  logic [NCH-1:0] event_i,
  output logic [NCH-1:0] irq_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    REG_CFG  = 2'd0,
    REG_CNT  = 2'd1,
    REG_CMP  = 2'd2,
    REG_STAT = 2'd3
  } reg_e;

  logic           access;
  logic           addr_err;
  logic           wr_en;
  logic           rd_en;
  logic [3:0]     ch_sel;
  reg_e           reg_sel;
  logic [NCH-1:0] en_vec;
  logic [NCH-1:0] match_q_vec;
  logic [NCH:0]   casc_vec;
  logic [31:0]    rd_vals [NCH];

  assign access   = PSEL & PENABLE;
  assign addr_err = ({20'd0, PADDR} >= 32'(NCH * 16)) || (PADDR[1:0] != 2'b00);
  assign wr_en    = access & PWRITE & ~addr_err;
  assign rd_en    = access & ~PWRITE & ~addr_err;
  assign ch_sel   = PADDR[7:4];
  assign reg_sel  = reg_e'(PADDR[3:2]);
  assign PREADY   = 1'b1;
  assign PSLVERR  = access & addr_err;
  assign busy_o   = |en_vec;
  // Bit c of casc_vec is channel c-1's match pulse; channel 0 sees a constant 0.
  assign casc_vec = {match_q_vec, 1'b0};

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ch_sel == c[3:0]) PRDATA = rd_vals[c];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             en_r, oneshot_r, irq_en_r, match_r, match_q_r, event_q_r;
    logic [1:0]       src_r;
    logic [PSC_W-1:0] presc_r, psc_r;
    logic [CNT_W-1:0] cnt_r, cmp_r;
    logic             sel, cfg_wr, cnt_wr, cmp_wr, stat_wr;
    logic             pulse, tick, step, hit;
    logic [31:0]      rd_val;

    assign sel     = wr_en & (ch_sel == 4'(c));
    assign cfg_wr  = sel & (reg_sel == REG_CFG);
    assign cnt_wr  = sel & (reg_sel == REG_CNT);
    assign cmp_wr  = sel & (reg_sel == REG_CMP);
    assign stat_wr = sel & (reg_sel == REG_STAT);

    always_comb begin
      pulse = 1'b0;
      case (src_r)
        2'd0:    pulse = 1'b1;
        2'd1:    pulse = event_i[c] & ~event_q_r;
        2'd2:    pulse = casc_vec[c];
        default: pulse = 1'b0;
      endcase
    end

    assign tick = en_r & ~stoptimer_i & pulse;
    assign step = tick & (psc_r == presc_r);
    assign hit  = step & (cnt_r == cmp_r);

    // Later assignments override earlier ones: APB writes beat the count step,
    // a CFG write beats the one-shot EN clear, and a match beats the W1C clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        en_r      <= 1'b0;
        oneshot_r <= 1'b0;
        irq_en_r  <= 1'b0;
        src_r     <= '0;
        presc_r   <= '0;
        psc_r     <= '0;
        cnt_r     <= '0;
        cmp_r     <= '1;
        match_r   <= 1'b0;
        match_q_r <= 1'b0;
        event_q_r <= 1'b0;
      end else begin
        event_q_r <= event_i[c];
        match_q_r <= hit;
        if (tick) psc_r <= (psc_r == presc_r) ? '0 : psc_r + PSC_W'(1);
        if (step) cnt_r <= hit ? '0 : cnt_r + CNT_W'(1);
        if (hit && oneshot_r) en_r <= 1'b0;
        if (cnt_wr) begin
          cnt_r <= PWDATA[CNT_W-1:0];
          psc_r <= '0;
        end
        if (cfg_wr) begin
          en_r      <= PWDATA[0];
          oneshot_r <= PWDATA[2];
          irq_en_r  <= PWDATA[3];
          src_r     <= PWDATA[5:4];
          presc_r   <= PWDATA[8 +: PSC_W];
          if (PWDATA[1]) begin
            cnt_r <= '0;
            psc_r <= '0;
          end
        end
        if (cmp_wr) cmp_r <= PWDATA[CNT_W-1:0];
        if (stat_wr && PWDATA[0]) match_r <= 1'b0;
        if (hit) match_r <= 1'b1;
      end
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        REG_CFG: begin
          rd_val[0]           = en_r;
          rd_val[2]           = oneshot_r;
          rd_val[3]           = irq_en_r;
          rd_val[5:4]         = src_r;
          rd_val[8 +: PSC_W]  = presc_r;
        end
        REG_CNT:  rd_val[CNT_W-1:0] = cnt_r;
        REG_CMP:  rd_val[CNT_W-1:0] = cmp_r;
        REG_STAT: rd_val[0]         = match_r;
        default:  rd_val = '0;
      endcase
    end

    assign rd_vals[c]     = rd_val;
    assign en_vec[c]      = en_r;
    assign match_q_vec[c] = match_q_r;
    assign irq_o[c]       = match_r & irq_en_r;
  end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc: directed scenarios plus randomized clock-source
// runs checked against an arithmetic model (steps = ticks / (PRESC+1)).
`timescale 1ns/1ps
module tb_apb_timer_mc;
  localparam int NCH   = 4;
  localparam int CNT_W = 32;
  localparam int PSC_W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           PSEL, PENABLE, PWRITE;
  logic [11:0]    PADDR;
  logic [31:0]    PWDATA;
  logic [31:0]    PRDATA;
  logic           PREADY;
  logic           PSLVERR;
  logic           stoptimer_i;
  logic [NCH-1:0] event_i;
  logic [NCH-1:0] irq_o;
  logic           busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  apb_timer_mc #(.NCH(NCH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .stoptimer_i(stoptimer_i), .event_i(event_i), .irq_o(irq_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // 'at' is the index of the clock edge that committed the write.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output int at, output logic err);
    @(negedge clk_i);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk_i);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge clk_i);
    #1 at = cyc;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int t;
    logic e;
    apb_write(a, d, t, e);
  endtask

  // 'at' is the number of edges seen when PRDATA was sampled.
  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err, output int at);
    @(negedge clk_i);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk_i);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    err = PSLVERR;
    at = cyc;
    @(posedge clk_i);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    int t;
    logic e;
    apb_read(a, d, e, t);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (irq_o !== '0) begin n_fail++; $display("FAIL reset_irq: got %h want 0", irq_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (PRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
    n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
    n_checks++; if (PREADY !== 1'b1) begin n_fail++; $display("FAIL pready: got %b want 1", PREADY); end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      rd(12'(c * 16 + 8), d);
      n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp ch%0d: got %h want ffffffff", c, d); end
      rd(12'(c * 16), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cfg ch%0d: got %h want 0", c, d); end
      rd(12'(c * 16 + 4), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cnt ch%0d: got %h want 0", c, d); end
      rd(12'(c * 16 + 12), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_stat ch%0d: got %h want 0", c, d); end
    end
  endtask

  task automatic test_basic;
    int e, dis;
    logic err;
    logic [31:0] d;
    wr(12'h008, 32'd4);
    apb_write(12'h000, 32'h0B, e, err);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_i); #1;
      n_checks++; if (irq_o[0] !== (k >= 5)) begin n_fail++; $display("FAIL basic_irq k=%0d: got %b want %b", k, irq_o[0], (k >= 5)); end
    end
    apb_write(12'h000, 32'h08, dis, err);
    rd(12'h004, d);
    n_checks++; if (d !== 32'((dis - e) % 5)) begin n_fail++; $display("FAIL basic_cnt: got %h want %h", d, (dis - e) % 5); end
    n_checks++; if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL basic_irq_hold: got %b want 1", irq_o[0]); end
    wr(12'h00C, 32'h1);
    n_checks++; if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL basic_w1c: got %b want 0", irq_o[0]); end
  endtask

  task automatic test_oneshot;
    int e;
    logic err;
    logic [31:0] d;
    wr(12'h018, 32'd1);
    apb_write(12'h010, 32'h20F, e, err);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_i); #1;
      n_checks++; if (busy_o !== (k < 6)) begin n_fail++; $display("FAIL oneshot_busy k=%0d: got %b want %b", k, busy_o, (k < 6)); end
      n_checks++; if (irq_o[1] !== (k >= 6)) begin n_fail++; $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq_o[1], (k >= 6)); end
    end
    rd(12'h014, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL oneshot_cnt: got %h want 0", d); end
    rd(12'h010, d);
    n_checks++; if (d !== 32'h20C) begin n_fail++; $display("FAIL oneshot_cfg: got %h want 20c", d); end
    rd(12'h01C, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL oneshot_stat: got %h want 1", d); end
    wr(12'h01C, 32'h1);
  endtask

  task automatic test_cascade;
    int e;
    logic err;
    wr(12'h018, 32'd2);
    wr(12'h01C, 32'h1);
    wr(12'h010, 32'h2B);
    wr(12'h008, 32'd1);
    apb_write(12'h000, 32'h03, e, err);
    // ch0 matches at edges 2,4,6..; ch1 steps one edge later, third step matches.
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      n_checks++; if (irq_o[1] !== (((k - 1) / 2) >= 3)) begin n_fail++; $display("FAIL cascade_irq k=%0d: got %b want %b", k, irq_o[1], (((k - 1) / 2) >= 3)); end
      n_checks++; if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL cascade_irq0_masked k=%0d: got %b want 0", k, irq_o[0]); end
    end
    wr(12'h000, 32'h0);
    wr(12'h010, 32'h0);
    wr(12'h00C, 32'h1);
    wr(12'h01C, 32'h1);
  endtask

  task automatic test_event;
    logic [31:0] d;
    int nexp = 0;
    wr(12'h028, 32'd100);
    wr(12'h020, 32'h13);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk_i); event_i[2] = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk_i);
      event_i[2] = 1'b0;
      nexp++;
      repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
    rd(12'h024, d);
    n_checks++; if (d !== 32'(nexp)) begin n_fail++; $display("FAIL event_cnt: got %h want %h", d, nexp); end
    @(negedge clk_i); stoptimer_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk_i); event_i[2] = 1'b1;
      repeat (3) @(negedge clk_i);
      event_i[2] = 1'b0;
      repeat (2) @(negedge clk_i);
    end
    stoptimer_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rd(12'h024, d);
    n_checks++; if (d !== 32'(nexp)) begin n_fail++; $display("FAIL event_freeze_cnt: got %h want %h", d, nexp); end
    rd(12'h02C, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL event_stat: got %h want 0", d); end
    wr(12'h020, 32'h0);
  endtask

  task automatic test_wrap_priority;
    int e, w, dis;
    logic err;
    logic [31:0] d, expv;
    wr(12'h030, 32'h0);
    wr(12'h038, 32'h10);
    wr(12'h034, 32'hFFFF_FFFF);
    apb_write(12'h030, 32'h1, e, err);
    apb_write(12'h030, 32'h0, dis, err);
    rd(12'h034, d);
    expv = 32'hFFFF_FFFF + 32'(dis - e);
    n_checks++; if (d !== expv) begin n_fail++; $display("FAIL wrap_cnt: got %h want %h", d, expv); end
    rd(12'h03C, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_no_match: got %h want 0", d); end
    wr(12'h038, 32'h1000);
    apb_write(12'h030, 32'h1, e, err);
    apb_write(12'h034, 32'h1234, w, err);
    apb_write(12'h030, 32'h0, dis, err);
    rd(12'h034, d);
    expv = 32'h1234 + 32'(dis - w);
    n_checks++; if (d !== expv) begin n_fail++; $display("FAIL cntwr_vs_step: got %h want %h", d, expv); end
    // One-shot CMP=1, PRESC=0: the single match lands two edges after enable.
    wr(12'h038, 32'h1);
    apb_write(12'h030, 32'h7, e, err);
    apb_write(12'h03C, 32'h1, w, err);
    rd(12'h03C, d);
    expv = 32'(w <= e + 2);
    n_checks++; if (d !== expv) begin n_fail++; $display("FAIL match_vs_w1c: got %h want %h", d, expv); end
    wr(12'h030, 32'h0);
    wr(12'h03C, 32'h1);
  endtask

  task automatic test_err;
    int t;
    logic err;
    logic [31:0] d;
    wr(12'h000, 32'h08);
    apb_read(12'(NCH * 16), d, err, t);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_rd_range_pslverr: got %b want 1", err); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL err_rd_range_data: got %h want 0", d); end
    apb_read(12'h002, d, err, t);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_rd_unaligned_pslverr: got %b want 1", err); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL err_rd_unaligned_data: got %h want 0", d); end
    apb_write(12'h002, 32'h3, t, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wr_unaligned_pslverr: got %b want 1", err); end
    apb_write(12'(NCH * 16), 32'h3, t, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wr_range_pslverr: got %b want 1", err); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL err_wr_busy: got %b want 0", busy_o); end
    apb_read(12'h000, d, err, t);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ok_rd_pslverr: got %b want 0", err); end
    n_checks++; if (d !== 32'h08) begin n_fail++; $display("FAIL err_wr_no_effect: got %h want 8", d); end
    wr(12'h000, 32'h0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      int c, cmpv, p, os, w, e, at, steps;
      logic err, done;
      logic [11:0] base;
      logic [31:0] cfg, d, expv;
      c = $urandom_range(0, NCH - 1);
      cmpv = $urandom_range(0, 6);
      p = $urandom_range(0, 3);
      os = $urandom_range(0, 1);
      w = $urandom_range(0, 25);
      base = 12'(c * 16);
      cfg = 32'h3 | 32'(os << 2) | 32'(p << 8);
      wr(base, 32'h0);
      wr(base + 12'h8, 32'(cmpv));
      wr(base + 12'hC, 32'h1);
      apb_write(base, cfg, e, err);
      repeat (w) @(posedge clk_i);
      apb_read(base + 12'h4, d, err, at);
      steps = (at - e) / (p + 1);
      done = (steps > cmpv);
      expv = (os != 0) ? (done ? 32'h0 : 32'(steps)) : 32'(steps % (cmpv + 1));
      n_checks++; if (d !== expv) begin n_fail++; $display("FAIL rand_cnt it%0d ch%0d: got %h want %h", it, c, d, expv); end
      apb_read(base + 12'hC, d, err, at);
      steps = (at - e) / (p + 1);
      expv = 32'(steps > cmpv);
      n_checks++; if (d !== expv) begin n_fail++; $display("FAIL rand_stat it%0d ch%0d: got %h want %h", it, c, d, expv); end
      apb_read(base, d, err, at);
      steps = (at - e) / (p + 1);
      expv = ((os != 0) && (steps > cmpv)) ? (cfg & ~32'h3) : (cfg & ~32'h2);
      n_checks++; if (d !== expv) begin n_fail++; $display("FAIL rand_cfg it%0d ch%0d: got %h want %h", it, c, d, expv); end
      wr(base, 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    logic [31:0] d;
    wr(12'h008, 32'd2);
    wr(12'h000, 32'h0B);
    while (irq_o[0] !== 1'b1 && t < 20) begin
      @(posedge clk_i); #1;
      t++;
    end
    n_checks++; if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL mid_irq_rise: got %b want 1 (timeout)", irq_o[0]); end
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    n_checks++; if (irq_o !== '0) begin n_fail++; $display("FAIL mid_rst_irq: got %h want 0", irq_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    rd(12'h008, d);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_rst_cmp: got %h want ffffffff", d); end
    rd(12'h004, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_cnt: got %h want 0", d); end
    rd(12'h000, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_cfg: got %h want 0", d); end
  endtask

  initial begin
    rst_i = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    stoptimer_i = 1'b0;
    event_i = '0;
    test_reset;
    test_basic;
    test_oneshot;
    test_cascade;
    test_event;
    test_wrap_priority;
    test_err;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
